// File: rtl/chr_sram_reader.sv
// ---------------------------------------------------------------------------
// chr_sram_reader
//
// Serves PPU pattern-table byte reads from the CHR image that the CHR loader
// has already copied into a 16-bit SRAM. The PPU byte address, together with
// the mapper's 8 KB CHR bank, is mapped to an SRAM word. The block then runs
// a timed read cycle and returns the selected byte through a ready/valid
// handshake. Everything runs in the PPU clock domain.
//
// Parameters
//   CHR_BASE     SRAM word address of CHR bank 0
//   WAIT_CYCLES  extra cycles OE is held low before sampling (0..7)
//
// Optional feature macro
//   CHR_READER_CACHE_EN  adds a one-word cache. A request that hits the cache
//                        completes in one cycle and makes no SRAM access.
//
// Ports
//   i_clk         PPU clock
//   i_rstn        synchronous active-low reset
//   i_load_done   CHR image valid in SRAM
//   i_bank        CHR 8 KB bank select
//   i_req         read request, taken only while o_ready=1
//   i_ppu_addr    PPU pattern-table byte address
//   o_ready       block can accept a request
//   o_rvalid      one-cycle pulse, o_rdata valid
//   o_rdata       returned byte, held until the next o_rvalid
//   o_sram_addr   SRAM word address
//   o_sram_wdata  always zero (read-only client)
//   i_sram_rdata  SRAM read data
//   o_sram_oe_n / o_sram_we_n / o_sram_ub_n / o_sram_lb_n  active-low strobes
// ---------------------------------------------------------------------------
module chr_sram_reader #(
   parameter logic [19:0] CHR_BASE    = 20'h80000,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_load_done,
   input  logic [6:0]  i_bank,
   input  logic        i_req,
   input  logic [12:0] i_ppu_addr,
   output logic        o_ready,
   output logic        o_rvalid,
   output logic [7:0]  o_rdata,
   output logic [19:0] o_sram_addr,
   output logic [15:0] o_sram_wdata,
   input  logic [15:0] i_sram_rdata,
   output logic        o_sram_oe_n,
   output logic        o_sram_we_n,
   output logic        o_sram_ub_n,
   output logic        o_sram_lb_n
);

   typedef enum logic [1:0] {
      ST_OFF    = 2'b00,
      ST_READY  = 2'b01,
      ST_ACCESS = 2'b10
   } state_t;

   // Last value of the wait counter. On that edge the SRAM data is sampled.
   localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

   state_t      state_r, state_s;
   logic [2:0]  wait_cnt_r, wait_cnt_s;
   logic        sel_hi_r, sel_hi_s;
   logic [19:0] byte_addr_s;
   logic [19:0] word_addr_s;
   logic        cache_hit_s;
   logic [7:0]  hit_data_s;
   logic        rvalid_s;
   logic [7:0]  rdata_s;
   logic [19:0] sram_addr_s;
   logic        ready_s;
   logic        strobe_n_s;

   // Chooses the low byte (hi=0) or the high byte (hi=1) of an SRAM word.
   function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
      logic [7:0] b;
      if (hi) begin
         b = word[15:8];
      end else begin
         b = word[7:0];
      end
      return b;
   endfunction

   // The block never writes SRAM.
   assign o_sram_wdata = 16'h0000;

`ifdef CHR_READER_CACHE_EN
   logic        cache_valid_r, cache_valid_s;
   logic [19:0] cache_addr_r, cache_addr_s;
   logic [15:0] cache_data_r, cache_data_s;

   // Cache lookup, fill on every completed SRAM read, and invalidation
   // whenever the CHR image is not valid.
   always_comb begin
      cache_valid_s = cache_valid_r;
      cache_addr_s  = cache_addr_r;
      cache_data_s  = cache_data_r;
      cache_hit_s   = cache_valid_r && (cache_addr_r == word_addr_s);
      hit_data_s    = byte_sel(cache_data_r, byte_addr_s[0]);
      if (!i_load_done) begin
         cache_valid_s = 1'b0;
      end else if ((state_r == ST_ACCESS) && (wait_cnt_r == WAIT_LAST)) begin
         cache_valid_s = 1'b1;
         cache_addr_s  = o_sram_addr;
         cache_data_s  = i_sram_rdata;
      end else begin
         cache_valid_s = cache_valid_r;
      end
   end

   // Cache storage.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         cache_valid_r <= 1'b0;
         cache_addr_r  <= 20'h00000;
         cache_data_r  <= 16'h0000;
      end else begin
         cache_valid_r <= cache_valid_s;
         cache_addr_r  <= cache_addr_s;
         cache_data_r  <= cache_data_s;
      end
   end
`else
   assign cache_hit_s = 1'b0;
   assign hit_data_s  = 8'h00;
`endif

   // Address mapping, next-state logic and next values of all registered outputs.
   always_comb begin
      byte_addr_s = {i_bank, i_ppu_addr};
      // 20-bit add; any carry out of bit 19 is dropped.
      word_addr_s = CHR_BASE + {1'b0, byte_addr_s[19:1]};
      state_s     = state_r;
      wait_cnt_s  = wait_cnt_r;
      sel_hi_s    = sel_hi_r;
      rvalid_s    = 1'b0;
      rdata_s     = o_rdata;
      sram_addr_s = o_sram_addr;
      case (state_r)
         ST_OFF: begin
            if (i_load_done) begin
               state_s = ST_READY;
            end else begin
               state_s = ST_OFF;
            end
         end
         ST_READY: begin
            if (!i_load_done) begin
               state_s = ST_OFF;
            end else if (i_req && cache_hit_s) begin
               rvalid_s = 1'b1;
               rdata_s  = hit_data_s;
            end else if (i_req) begin
               state_s     = ST_ACCESS;
               wait_cnt_s  = 3'd0;
               sel_hi_s    = byte_addr_s[0];
               sram_addr_s = word_addr_s;
            end else begin
               state_s = ST_READY;
            end
         end
         ST_ACCESS: begin
            // If the image goes invalid mid-access, the read is dropped silently.
            if (!i_load_done) begin
               state_s = ST_OFF;
            end else if (wait_cnt_r == WAIT_LAST) begin
               state_s  = ST_READY;
               rvalid_s = 1'b1;
               rdata_s  = byte_sel(i_sram_rdata, sel_hi_r);
            end else begin
               wait_cnt_s = wait_cnt_r + 3'd1;
            end
         end
         default: begin
            state_s = ST_OFF;
         end
      endcase
      // Outputs follow the next state so that they come straight from flops.
      ready_s    = (state_s == ST_READY);
      strobe_n_s = (state_s != ST_ACCESS);
   end

   // State and output registers.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_r     <= ST_OFF;
         wait_cnt_r  <= 3'd0;
         sel_hi_r    <= 1'b0;
         o_ready     <= 1'b0;
         o_rvalid    <= 1'b0;
         o_rdata     <= 8'h00;
         o_sram_addr <= 20'h00000;
         o_sram_oe_n <= 1'b1;
         o_sram_we_n <= 1'b1;
         o_sram_ub_n <= 1'b1;
         o_sram_lb_n <= 1'b1;
      end else begin
         state_r     <= state_s;
         wait_cnt_r  <= wait_cnt_s;
         sel_hi_r    <= sel_hi_s;
         o_ready     <= ready_s;
         o_rvalid    <= rvalid_s;
         o_rdata     <= rdata_s;
         o_sram_addr <= sram_addr_s;
         o_sram_oe_n <= strobe_n_s;
         o_sram_we_n <= 1'b1;
         o_sram_ub_n <= strobe_n_s;
         o_sram_lb_n <= strobe_n_s;
      end
   end

endmodule
